// File: rtl/pipelined_adder.sv
// Add/subtract unit that resolves one CW-bit chunk per clock, rippling the chunk
// carry through a valid/ready pipeline whose last stage drives the outputs.
module pipelined_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             overflow,
  output logic             zero
);

  localparam int CW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  logic advance;
  logic accept;

  logic             vld_p [STAGES];
  logic [WIDTH-1:0] a_p   [STAGES];
  logic [WIDTH-1:0] eb_p  [STAGES];
  logic [WIDTH-1:0] sum_p [STAGES];
  logic             cry_p [STAGES];
  logic             ovf_p;
  logic             zero_p;

  logic             src_vld [STAGES];
  logic [WIDTH-1:0] src_a   [STAGES];
  logic [WIDTH-1:0] src_eb  [STAGES];
  logic [WIDTH-1:0] src_sum [STAGES];
  logic             src_cry [STAGES];
  logic [WIDTH-1:0] sum_n   [STAGES];
  logic             cry_n   [STAGES];
  logic [CW:0]      part;
  logic             ovf_n;
  logic             zero_n;

  function automatic logic [CW:0] chunk_add(input logic [CW-1:0] x,
                                            input logic [CW-1:0] y,
                                            input logic          c);
    return {1'b0, x} + {1'b0, y} + {{CW{1'b0}}, c};
  endfunction

  assign advance   = ~vld_p[LAST] | out_ready;
  assign in_ready  = advance;
  assign accept    = in_valid & advance;
  assign out_valid = vld_p[LAST];
  assign s         = sum_p[LAST];
  assign cout      = cry_p[LAST];
  assign overflow  = ovf_p;
  assign zero      = zero_p;

  always_comb begin
    // stage 0 source: operand preparation at accept
    src_vld[0] = accept;
    src_a[0]   = a;
    src_eb[0]  = sub ? ~b : b;
    src_sum[0] = '0;
    src_cry[0] = sub ? 1'b1 : cin;
    for (int k = 1; k < STAGES; k++) begin
      src_vld[k] = vld_p[k-1];
      src_a[k]   = a_p[k-1];
      src_eb[k]  = eb_p[k-1];
      src_sum[k] = sum_p[k-1];
      src_cry[k] = cry_p[k-1];
    end
    part = '0;
    for (int k = 0; k < STAGES; k++) begin
      part     = chunk_add(src_a[k][k*CW +: CW], src_eb[k][k*CW +: CW], src_cry[k]);
      sum_n[k] = src_sum[k];
      sum_n[k][k*CW +: CW] = part[CW-1:0];
      cry_n[k] = part[CW];
    end
    // flags use the sign bits that travelled with the operands
    ovf_n  = (src_a[LAST][WIDTH-1] == src_eb[LAST][WIDTH-1]) &&
             (sum_n[LAST][WIDTH-1] != src_a[LAST][WIDTH-1]);
    zero_n = ~|sum_n[LAST];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) vld_p[k] <= 1'b0;
      sum_p[LAST] <= '0;
      cry_p[LAST] <= 1'b0;
      ovf_p       <= 1'b0;
      zero_p      <= 1'b0;
    end else if (advance) begin
      // stage boundary: every stage shifts forward together
      for (int k = 0; k < STAGES; k++) begin
        vld_p[k] <= src_vld[k];
        a_p[k]   <= src_a[k];
        eb_p[k]  <= src_eb[k];
        sum_p[k] <= sum_n[k];
        cry_p[k] <= cry_n[k];
      end
      ovf_p  <= ovf_n;
      zero_p <= zero_n;
    end
  end

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder at STAGES = 4, 1 and 32 sharing one stimulus stream,
// each instance scored against an arithmetic reference queue.
`timescale 1ns/1ps
module tb_pipelined_adder;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         sub = 1'b0;
  logic         cin = 1'b0;
  logic         out_ready = 1'b1;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  bit lat_on = 1'b1;
  bit hist [4096];

  typedef struct {
    logic [W-1:0] s;
    logic         c;
    logic         ov;
    logic         z;
    int           cyc;
    bit           lat;
  } exp_t;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: true integer arithmetic, then wrap and classify.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic sb, input logic ci);
    exp_t   m;
    longint ux, uy, sx, sy, ru, rs;
    longint lim;
    lim = 64'sd2147483647;
    ux  = longint'({32'd0, x});
    uy  = longint'({32'd0, y});
    sx  = longint'($signed(x));
    sy  = longint'($signed(y));
    if (sb) begin
      ru  = ux - uy;
      rs  = sx - sy;
      m.c = (ux >= uy);
    end else begin
      ru  = ux + uy + longint'(ci);
      rs  = sx + sy + longint'(ci);
      m.c = (ru >= 64'sh1_0000_0000);
    end
    m.s   = ru[W-1:0];
    m.ov  = (rs > lim) || (rs < -lim - 1);
    m.z   = (m.s == '0);
    m.cyc = 0;
    m.lat = 1'b0;
    return m;
  endfunction

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam int SK = (g == 0) ? 4 : ((g == 1) ? 1 : 32);
    logic         rdy, vld, co, ovf, zro;
    logic [W-1:0] sum;
    exp_t         q[$];
    int           depth = 0;

    pipelined_adder #(.WIDTH(W), .STAGES(SK)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy),
      .sub(sub), .cin(cin), .a(a), .b(b),
      .out_valid(vld), .out_ready(out_ready),
      .s(sum), .cout(co), .overflow(ovf), .zero(zro)
    );

    always @(negedge clk) begin : mon
      exp_t e;
      check($sformatf("in_ready_st%0d", SK), 64'(rdy), 64'(!(vld && !out_ready)));
      if (vld) begin
        if (q.size() == 0) begin
          check($sformatf("unexpected_result_st%0d", SK), 64'(vld), 64'(0));
        end else begin
          e = q[0];
          check($sformatf("s_st%0d", SK),    64'(sum), 64'(e.s));
          check($sformatf("cout_st%0d", SK), 64'(co),  64'(e.c));
          check($sformatf("ovf_st%0d", SK),  64'(ovf), 64'(e.ov));
          check($sformatf("zero_st%0d", SK), 64'(zro), 64'(e.z));
          if (out_ready) begin
            if (e.lat) check($sformatf("latency_st%0d", SK), 64'(cyc - e.cyc), 64'(SK));
            void'(q.pop_front());
          end
        end
      end
      if (in_valid && rdy) begin
        e     = model(a, b, sub, cin);
        e.cyc = cyc;
        e.lat = lat_on;
        q.push_back(e);
      end
      if (rst) q.delete();
      depth = q.size();
    end
  end

  always @(negedge clk) if (cyc < 4096) hist[cyc] <= gen_dut[0].vld;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_check(input string tag);
    check({tag, "_st4"},  64'(gen_dut[0].depth), 64'(0));
    check({tag, "_st1"},  64'(gen_dut[1].depth), 64'(0));
    check({tag, "_st32"}, 64'(gen_dut[2].depth), 64'(0));
  endtask

  // One operand set into an idle pipe; exact timing checked on the 4-stage unit.
  task automatic send_one(input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic sb, input logic ci,
                          input logic [W-1:0] es, input logic ec,
                          input logic eov, input logic ez);
    step();
    a = x; b = y; sub = sb; cin = ci; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i < 4) begin
        check("dir_early_valid", 64'(gen_dut[0].vld), 64'(0));
      end else begin
        check("dir_valid", 64'(gen_dut[0].vld), 64'(1));
        check("dir_s",     64'(gen_dut[0].sum), 64'(es));
        check("dir_cout",  64'(gen_dut[0].co),  64'(ec));
        check("dir_ovf",   64'(gen_dut[0].ovf), 64'(eov));
        check("dir_zero",  64'(gen_dut[0].zro), 64'(ez));
      end
    end
  endtask

  initial begin
    int t0;
    logic [W-1:0] pick [5];

    // reset
    repeat (2) step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid", 64'(gen_dut[0].vld), 64'(0));
    check("rst_s",     64'(gen_dut[0].sum), 64'(0));
    check("rst_flags", 64'({gen_dut[0].co, gen_dut[0].ovf, gen_dut[0].zro}), 64'(0));
    check("rst_ready", 64'(gen_dut[0].rdy), 64'(1));
    check("rst_valid_st32", 64'(gen_dut[2].vld), 64'(0));

    // directed vectors
    send_one(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 32'h0,         1'b1, 1'b0, 1'b1);
    send_one(32'h7FFF_FFFF, 32'h0, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    send_one(32'h5,         32'h7, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    send_one(32'h7,         32'h5, 1'b1, 1'b0, 32'h2,         1'b1, 1'b0, 1'b0);
    send_one(32'h8000_0000, 32'h1, 1'b1, 1'b0, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    repeat (40) step();
    drain_check("dir_drain");

    // throughput: 8 back-to-back sets
    t0 = 0;
    for (int i = 0; i < 8; i++) begin
      a = 32'(i); b = 32'(i) * 32'h1111_1111; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
      if (i == 0) t0 = cyc;
      step();
    end
    in_valid = 1'b0;
    repeat (6) step();
    check("tput_pre", 64'(hist[t0 + 3]), 64'(0));
    for (int i = 0; i < 8; i++) check($sformatf("tput_valid_%0d", i), 64'(hist[t0 + 4 + i]), 64'(1));
    check("tput_post", 64'(hist[t0 + 12]), 64'(0));
    repeat (40) step();
    drain_check("tput_drain");

    // backpressure while streaming
    lat_on = 1'b0;
    for (int i = 0; i < 16; i++) begin
      a = $urandom; b = $urandom; sub = 1'($urandom); cin = 1'($urandom);
      in_valid  = 1'b1;
      out_ready = !(i >= 5 && i < 10);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (40) step();
    drain_check("bp_drain");

    // reset with results in flight
    lat_on = 1'b1;
    for (int i = 0; i < 3; i++) begin
      a = $urandom; b = $urandom; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0; rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", 64'(gen_dut[0].vld), 64'(0));
    check("mid_rst_s",     64'(gen_dut[0].sum), 64'(0));
    check("mid_rst_ready", 64'(gen_dut[0].rdy), 64'(1));
    repeat (40) step();
    drain_check("rst_drain");

    // randomized traffic with random backpressure and corner operands
    lat_on = 1'b0;
    pick[1] = 32'h0; pick[2] = 32'hFFFF_FFFF; pick[3] = 32'h8000_0000; pick[4] = 32'h7FFF_FFFF;
    for (int i = 0; i < 600; i++) begin
      pick[0] = $urandom;
      a = (($urandom_range(0, 3)) == 0) ? pick[$urandom_range(1, 4)] : pick[0];
      pick[0] = $urandom;
      b = (($urandom_range(0, 3)) == 0) ? pick[$urandom_range(1, 4)] : pick[0];
      sub       = 1'($urandom);
      cin       = 1'($urandom);
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      step();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (60) step();
    drain_check("rand_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
